// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: steps one digit per scan_clk rise, snapshots a frame
// per full scan, applies blanking / leading-zero suppression and anode dead time.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DEAD_CYCLES  = 16,
  parameter int ANODE_ACT_LO = 1,
  parameter int SEG_ACT_LO   = 1,
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDXW-1:0]         digit_idx,
  output logic                    scan_tick
);

  localparam int CNTW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACT_LO != 0) ? '1 : '0;
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LO != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACT_LO != 0);

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Bit i set when digit i (i>0) and every digit above it are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic run;
    m   = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      run  = run & (d[4*k +: 4] == 4'h0);
      m[k] = run;
    end
    return m;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] anode_drive(input logic [IDXW-1:0] i,
                                                        input logic dark);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      oh[k] = (i == IDXW'(k)) && !dark;
    return (ANODE_ACT_LO != 0) ? ~oh : oh;
  endfunction

  logic                    scan_q;
  logic                    scan_rise;
  logic [IDXW-1:0]         idx_q, idx_nxt;
  logic [4*NUM_DIGITS-1:0] frm_digits_q, frm_digits_nxt;
  logic [NUM_DIGITS-1:0]   frm_dp_q, frm_dp_nxt;
  logic [NUM_DIGITS-1:0]   frm_blank_q, frm_blank_nxt;
  logic [NUM_DIGITS-1:0]   dark_vec;
  logic [3:0]              sel_digit;
  logic                    sel_dark, sel_dp;
  logic                    cur_dark_q;
  logic [CNTW-1:0]         dead_cnt_q;
  logic [6:0]              seg_hi;

  assign scan_rise = scan_clk & ~scan_q;
  assign digit_idx = idx_q;

  // Next index, next frame snapshot and the selected digit's attributes
  always_comb begin
    idx_nxt        = idx_q;
    frm_digits_nxt = frm_digits_q;
    frm_dp_nxt     = frm_dp_q;
    frm_blank_nxt  = frm_blank_q;
    if (scan_rise) begin
      idx_nxt = (idx_q == IDXW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (idx_nxt == '0) begin
        frm_digits_nxt = digits_in;
        frm_dp_nxt     = dp_in;
        frm_blank_nxt  = blank_in;
      end
    end
    dark_vec  = frm_blank_nxt | (lz_blank ? lz_mask(frm_digits_nxt) : '0);
    sel_digit = 4'h0;
    sel_dark  = 1'b1;
    sel_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IDXW'(k)) begin
        sel_digit = frm_digits_nxt[4*k +: 4];
        sel_dark  = dark_vec[k];
        sel_dp    = frm_dp_nxt[k];
      end
    end
    seg_hi = sel_dark ? 7'h00 : hex_decode(sel_digit);
  end

  // Output register stage: seg/dp switch immediately, anode waits out the dead time
  always_ff @(posedge clk) begin
    scan_q <= scan_clk;
    if (reset) begin
      idx_q        <= IDXW'(NUM_DIGITS - 1);
      scan_tick    <= 1'b0;
      dead_cnt_q   <= '0;
      cur_dark_q   <= 1'b1;
      frm_digits_q <= '0;
      frm_dp_q     <= '0;
      frm_blank_q  <= '1;
      anode        <= ANODE_OFF;
      seg          <= SEG_OFF;
      dp           <= DP_OFF;
    end else begin
      scan_tick    <= scan_rise;
      idx_q        <= idx_nxt;
      frm_digits_q <= frm_digits_nxt;
      frm_dp_q     <= frm_dp_nxt;
      frm_blank_q  <= frm_blank_nxt;
      if (scan_rise) begin
        dead_cnt_q <= CNTW'(DEAD_CYCLES);
        cur_dark_q <= sel_dark;
        seg        <= (SEG_ACT_LO != 0) ? ~seg_hi : seg_hi;
        dp         <= (SEG_ACT_LO != 0) ? ~(sel_dp & ~sel_dark) : (sel_dp & ~sel_dark);
        anode      <= (DEAD_CYCLES == 0) ? anode_drive(idx_nxt, sel_dark) : ANODE_OFF;
      end else if (dead_cnt_q != '0) begin
        dead_cnt_q <= dead_cnt_q - 1'b1;
        anode      <= (dead_cnt_q == CNTW'(1)) ? anode_drive(idx_q, cur_dark_q) : ANODE_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: expected per-slot outputs are queued when a frame is
// presented and popped as each scan step is produced.
module tb_seg7_scan_driver;

  localparam int DEAD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  // Active-high {g..a} patterns for hex 0..F
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DEAD_CYCLES(DEAD), .ANODE_ACT_LO(1), .SEG_ACT_LO(1)
  ) dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_blank(lz_blank), .anode(anode),
    .seg(seg), .dp(dp), .digit_idx(digit_idx), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic [3:0] dpv,
                                 input logic [3:0] bl, input logic lz, input int i);
    exp_t e;
    logic dark;
    logic [3:0] h;
    h      = d[4*i +: 4];
    dark   = bl[i] || (lz && (i > 0) && ((d >> (4 * i)) == 16'h0));
    e.idx  = 2'(i);
    e.an   = dark ? 4'hF : ~(4'b0001 << i);
    e.seg  = dark ? 7'h7F : ~seg_tab[h];
    e.dp   = ~(dpv[i] & ~dark);
    return e;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 4; i++)
      sb.push_back(model(digits_in, dp_in, blank_in, lz_blank, i));
  endtask

  task automatic scan_step();
    exp_t e;
    int n;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    @(negedge clk) scan_clk = 1'b1;
    n = 0;
    @(negedge clk);
    while (!scan_tick && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", 32'(scan_tick), 32'd1);
    chk("digit_idx", 32'(digit_idx), 32'(e.idx));
    chk("seg", 32'(seg), 32'(e.seg));
    chk("dp", 32'(dp), 32'(e.dp));
    chk("dead_anode_0", 32'(anode), 32'hF);
    @(negedge clk);
    chk("tick_one_cycle", 32'(scan_tick), 32'd0);
    chk("dead_anode_1", 32'(anode), 32'hF);
    @(negedge clk);
    chk("dead_anode_2", 32'(anode), 32'hF);
    @(negedge clk);
    chk("anode", 32'(anode), 32'(e.an));
    scan_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk("anode_hold", 32'(anode), 32'(e.an));
    chk("seg_hold", 32'(seg), 32'(e.seg));
  endtask

  initial begin
    reset     = 1'b1;
    scan_clk  = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    blank_in  = 4'b0000;
    lz_blank  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_idx", 32'(digit_idx), 32'd3);
    chk("rst_tick", 32'(scan_tick), 32'd0);

    // Basic scan of 1234
    push_frame();
    scan_step();
    chk("t1_seg_4", 32'(seg), 32'h19);
    chk("t1_anode_slot0", 32'(anode), 32'hE);
    scan_step();
    scan_step();
    scan_step();
    chk("t1_anode_slot3", 32'(anode), 32'h7);

    // Mid-frame change is ignored until the wrap
    push_frame();
    scan_step();
    scan_step();
    digits_in = 16'hABCD;
    scan_step();
    chk("t3_still_2", 32'(seg), 32'(~7'h5B & 7'h7F));
    scan_step();
    push_frame();
    scan_step();
    chk("t3_D_after_wrap", 32'(seg), 32'(~7'h5E & 7'h7F));
    scan_step();
    scan_step();
    scan_step();

    // Leading-zero suppression
    lz_blank  = 1'b1;
    digits_in = 16'h0050;
    push_frame();
    scan_step();
    chk("t2_slot0_0", 32'(seg), 32'h40);
    scan_step();
    chk("t2_slot1_5", 32'(seg), 32'h12);
    scan_step();
    chk("t2_slot2_dark", 32'(anode), 32'hF);
    scan_step();
    chk("t2_slot3_dark", 32'(seg), 32'h7F);
    digits_in = 16'h0000;
    push_frame();
    scan_step();
    chk("t2_zero_slot0_lit", 32'(anode), 32'hE);
    scan_step();
    scan_step();
    scan_step();

    // Decimal point and explicit blanking
    lz_blank  = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0100;
    blank_in  = 4'b0001;
    push_frame();
    scan_step();
    chk("t6_slot0_seg_dark", 32'(seg), 32'h7F);
    scan_step();
    scan_step();
    chk("t6_slot2_dp_lit", 32'(dp), 32'd0);
    scan_step();

    // Reset with scan_clk held high: no false edge on release
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    @(negedge clk);
    scan_clk = 1'b1;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_anode", 32'(anode), 32'hF);
    chk("t5_seg", 32'(seg), 32'h7F);
    chk("t5_idx", 32'(digit_idx), 32'd3);
    begin
      logic saw_tick;
      saw_tick = 1'b0;
      repeat (8) begin
        @(negedge clk);
        saw_tick = saw_tick | scan_tick;
      end
      chk("t5_no_tick_held", 32'(saw_tick), 32'd0);
    end
    chk("t5_idx_held", 32'(digit_idx), 32'd3);
    scan_clk = 1'b0;
    repeat (2) @(negedge clk);
    push_frame();
    scan_step();
    chk("t5_first_tick_loads", 32'(seg), 32'h19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
